sparse_conv_row: RTL
====================

SPARSE_CONV_ROW -- requirements
Module: sparse_conv_row

Interface
REQ-001 SHALL have parameter ROW_LENGTH, default 28, input row length in columns.
REQ-002 SHALL have parameter FILTER_SIZE, default 5, number of filter taps.
REQ-003 SHALL have parameter DATA_W, default 8, signed activation and weight width.
REQ-004 SHALL have parameter INDEX_W, default 8, column index width.
REQ-005 SHALL have parameter ACC_W, default 24, signed accumulator width.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  synchronous active-high reset.
REQ-008 SHALL have ports in_valid/in_ready  in/out  1  input beat handshake.
REQ-009 SHALL have ports in_index/in_data/in_last  input  INDEX_W/DATA_W/1  nonzero column, value, end of row.
REQ-010 SHALL have ports w_valid/w_tap/w_data  input  1/INDEX_W/DATA_W  weight write strobe, tap, value.
REQ-011 SHALL have ports out_valid/out_ready  out/in  1  output beat handshake.
REQ-012 SHALL have ports out_index/out_data/out_last  output  INDEX_W/ACC_W/1  output column, sum, final beat.
REQ-013 SHALL have port err_index  output  1  sticky out-of-range index flag.

Function
REQ-014 SHALL define OUT_LEN = ROW_LENGTH - FILTER_SIZE + 1 accumulators, held in registers.
REQ-015 SHALL have two states: ACCUM (in_ready=1, out_valid=0) and DRAIN (in_ready=0).
REQ-016 In ACCUM, on each accepted beat at column c, SHALL add in_data*w[c-o] to acc[o] for every o in 0..OUT_LEN-1 with 0 <= c-o < FILTER_SIZE, all taps in the same cycle.
REQ-017 Products SHALL be signed 2*DATA_W, sign-extended to ACC_W; accumulation SHALL wrap modulo 2^ACC_W without saturation.
REQ-018 A beat with in_index >= ROW_LENGTH SHALL contribute nothing and set err_index; err_index SHALL clear only on reset.
REQ-019 An accepted beat with in_last=1 SHALL be accumulated, then the state SHALL enter DRAIN on the next cycle.
REQ-020 In DRAIN, out_valid SHALL be 1 and out_index/out_data/out_last SHALL hold stable until out_ready=1.
REQ-021 Each output handshake SHALL zero the emitted accumulator; the handshake with out_last=1 SHALL return the state to ACCUM on the next cycle.
REQ-022 Output latency SHALL be one cycle from the in_last acceptance to the first out_valid.
REQ-023 A weight write SHALL occur only in ACCUM with no beat yet accepted in the current row. Otherwise it SHALL be ignored. Taps >= FILTER_SIZE SHALL be ignored.
REQ-024 A written weight SHALL take effect for beats accepted from the next cycle.
REQ-025 Duplicate or non-increasing indices within a row SHALL be accumulated as given.

Reset
REQ-026 Reset SHALL set the state to ACCUM, all accumulators and weights to 0, and err_index to 0.
REQ-027 Reset SHALL set out_valid, out_last, out_index and out_data to 0.
REQ-028 Reset asserted during DRAIN SHALL abandon the row with no further output beats.

Configuration
REQ-029 With SPARSE_OUT_EN defined, DRAIN SHALL emit only nonzero accumulators in increasing column order. Column OUT_LEN-1 SHALL always be emitted, even if zero, with out_last=1.
REQ-030 Without SPARSE_OUT_EN, DRAIN SHALL emit all OUT_LEN columns, indices 0..OUT_LEN-1, with out_last on column OUT_LEN-1.

Structure
REQ-031 A shared package SHALL hold the state enum and the default values of ROW_LENGTH, FILTER_SIZE, DATA_W, INDEX_W and ACC_W.
REQ-032 The OUT_LEN formula SHALL live in the shared package.
REQ-033 A single sub-module, sparse_tap_mac (one tap multiply and sign-extend), SHALL be instantiated FILTER_SIZE times.

Verification
REQ-034 Weights 1,2,3,4,5, then one beat (index 4, data 2, last) -> columns 0..4 = 10,8,6,4,2 and all others 0.
REQ-035 Same weights, one beat (index 27, data 2, last) -> column 23 = 10 and all others 0; sparse build emits exactly one beat.
REQ-036 One beat (index 30, data 1, last) -> err_index=1 and all outputs 0.
REQ-037 out_ready held 0 for 5 cycles in DRAIN -> the first beat stays stable and no beat is lost or duplicated.
REQ-038 Weight write after the first beat of a row -> ignored and old weights used; rst mid-DRAIN -> out_valid=0 the next cycle and the next row starts clean.
REQ-039 Data -128 at weight -128, repeated 600 times at one column -> accumulator wraps modulo 2^24.

Source files
------------

// File: rtl/sparse_conv_row_pkg.sv
// Shared types, default widths and the output-length formula for sparse_conv_row.
package sparse_conv_row_pkg;

  localparam int ROW_LENGTH_DEF  = 28;
  localparam int FILTER_SIZE_DEF = 5;
  localparam int DATA_W_DEF      = 8;
  localparam int INDEX_W_DEF     = 8;
  localparam int ACC_W_DEF       = 24;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_DRAIN = 1'b1
  } state_t;

  // Number of valid ("no padding") output columns of a 1-D convolution.
  function automatic int out_len(input int row_length, input int filter_size);
    return row_length - filter_size + 1;
  endfunction

endpackage

// File: rtl/sparse_tap_mac.sv
// One filter tap: signed activation x weight, sign-extended to the accumulator width.
module sparse_tap_mac
  import sparse_conv_row_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic signed [DATA_W-1:0] act,
  input  logic signed [DATA_W-1:0] weight,
  output logic signed [ACC_W-1:0]  prod
);

  function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [2*DATA_W-1:0] p);
    return ACC_W'(p);
  endfunction

  logic signed [2*DATA_W-1:0] full;

  assign full = (2*DATA_W)'(act) * (2*DATA_W)'(weight);
  assign prod = sext_prod(full);

endmodule

// File: rtl/sparse_conv_row.sv
// Row convolution over a sparse stream of (column, value) beats, drained column by column.
// Define SPARSE_OUT_EN to emit only nonzero columns (plus the final column) during drain.
module sparse_conv_row
  import sparse_conv_row_pkg::*;
#(
  parameter int ROW_LENGTH  = ROW_LENGTH_DEF,
  parameter int FILTER_SIZE = FILTER_SIZE_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int INDEX_W     = INDEX_W_DEF,
  parameter int ACC_W       = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INDEX_W-1:0] in_index,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_last,
  input  logic               w_valid,
  input  logic [INDEX_W-1:0] w_tap,
  input  logic [DATA_W-1:0]  w_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INDEX_W-1:0] out_index,
  output logic [ACC_W-1:0]   out_data,
  output logic               out_last,
  output logic               err_index
);

  localparam int OUT_LEN = out_len(ROW_LENGTH, FILTER_SIZE);

  state_t                    state;
  logic                      row_started;
  logic [INDEX_W-1:0]        ptr;
  logic [INDEX_W-1:0]        ptr_nxt;
  logic signed [DATA_W-1:0]  w     [FILTER_SIZE];
  logic signed [ACC_W-1:0]   prod  [FILTER_SIZE];
  logic signed [ACC_W-1:0]   acc   [OUT_LEN];
  logic signed [ACC_W-1:0]   acc_d [OUT_LEN];
  logic                      beat;
  logic                      in_range;
  logic                      beat_ok;
  logic                      w_ok;

  assign in_ready  = (state == ST_ACCUM);
  assign out_valid = (state == ST_DRAIN);
  assign out_last  = out_valid && (int'(ptr) == OUT_LEN - 1);
  assign out_index = out_valid ? ptr : '0;

  assign beat     = in_valid && in_ready;
  assign in_range = int'(in_index) < ROW_LENGTH;
  assign beat_ok  = beat && in_range;
  assign w_ok     = w_valid && (state == ST_ACCUM) && !row_started &&
                    (int'(w_tap) < FILTER_SIZE);

  for (genvar t = 0; t < FILTER_SIZE; t++) begin : g_tap
    sparse_tap_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
    ) u_mac (
      .act    ($signed(in_data)),
      .weight (w[t]),
      .prod   (prod[t])
    );
  end

  // Column c feeds acc[o] through tap c-o; each accumulator sees at most one tap per beat.
  always_comb begin
    for (int o = 0; o < OUT_LEN; o++) begin
      acc_d[o] = acc[o];
      if (beat_ok) begin
        for (int t = 0; t < FILTER_SIZE; t++) begin
          if (int'(in_index) == o + t) acc_d[o] = acc[o] + prod[t];
        end
      end else if (out_valid && out_ready && (int'(ptr) == o)) begin
        acc_d[o] = '0;
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int o = 0; o < OUT_LEN; o++) begin
      if (out_valid && (int'(ptr) == o)) out_data = acc[o];
    end
  end

`ifdef SPARSE_OUT_EN
  // Emitted columns are zeroed in acc_d, so the lowest nonzero one is always the next to send.
  always_comb begin
    ptr_nxt = INDEX_W'(OUT_LEN - 1);
    for (int o = OUT_LEN - 2; o >= 0; o--) begin
      if (acc_d[o] != '0) ptr_nxt = INDEX_W'(o);
    end
  end
`else
  always_comb begin
    ptr_nxt = out_valid ? ptr + INDEX_W'(1) : '0;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_ACCUM;
      row_started <= 1'b0;
      ptr         <= '0;
      err_index   <= 1'b0;
      for (int t = 0; t < FILTER_SIZE; t++) w[t] <= '0;
      for (int o = 0; o < OUT_LEN; o++) acc[o] <= '0;
    end else begin
      for (int o = 0; o < OUT_LEN; o++) acc[o] <= acc_d[o];
      if (w_ok) begin
        for (int t = 0; t < FILTER_SIZE; t++) begin
          if (int'(w_tap) == t) w[t] <= $signed(w_data);
        end
      end
      if (beat && !in_range) err_index <= 1'b1;
      if (state == ST_ACCUM) begin
        if (beat) begin
          row_started <= 1'b1;
          if (in_last) begin
            state <= ST_DRAIN;
            ptr   <= ptr_nxt;
          end
        end
      end else if (out_ready) begin
        if (out_last) begin
          state       <= ST_ACCUM;
          row_started <= 1'b0;
          ptr         <= '0;
        end else begin
          ptr <= ptr_nxt;
        end
      end
    end
  end

endmodule
